// File: rtl/tile_pkg.sv
// tile_pkg: shared types for the tile loop sequencer.
package tile_pkg;
  localparam int DEF_CH_W = 7;
  localparam int DEF_PIX_W = 32;
  typedef enum logic [1:0] {PW = 2'd0, DW = 2'd1, STD = 2'd2, LIN = 2'd3} layer_e;
  typedef enum logic [2:0] {IDLE, CHECK, EMIT, STEP, FINISH} state_e;
  typedef struct packed {
    logic [DEF_CH_W-1:0] d_base;
    logic [DEF_CH_W-1:0] d_len;
    logic [DEF_CH_W-1:0] k_base;
    logic [DEF_CH_W-1:0] k_len;
    logic [DEF_PIX_W-1:0] n_base;
    logic [DEF_PIX_W-1:0] n_len;
    logic first_d;
    logic last_d;
  } tile_desc_t;
endpackage

// File: rtl/tile_axis_cnt.sv
// tile_axis_cnt: one loop axis with base register, remainder length and wrap flag.
module tile_axis_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] total,
  input  logic [W-1:0] tile,
  output logic [W-1:0] base,
  output logic [W-1:0] len,
  output logic         wrap
);
  logic [W:0] nxt, rem;
  // one extra bit so base+tile never overflows
  assign nxt  = {1'b0, base} + {1'b0, tile};
  assign rem  = {1'b0, total} - {1'b0, base};
  assign wrap = nxt >= {1'b0, total};
  assign len  = ({1'b0, tile} < rem) ? tile : rem[W-1:0];
  always_ff @(posedge clk) begin
    if (rst || clr) base <= '0;
    else if (inc) base <= wrap ? '0 : nxt[W-1:0];
  end
endmodule

// File: rtl/tile_loop_ctrl.sv
// tile_loop_ctrl: walks k/n/d tile loops and issues one descriptor per step.
module tile_loop_ctrl
  import tile_pkg::*;
#(
  parameter int CH_W = DEF_CH_W,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       layer_type,
  input  logic [CH_W-1:0]  in_C,
  input  logic [CH_W-1:0]  out_C,
  input  logic [PIX_W-1:0] num_pix,
  input  logic [CH_W-1:0]  tile_D,
  input  logic [CH_W-1:0]  tile_K,
  input  logic [PIX_W-1:0] tile_n,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [CH_W-1:0]  d_base,
  output logic [CH_W-1:0]  d_len,
  output logic [CH_W-1:0]  k_base,
  output logic [CH_W-1:0]  k_len,
  output logic [PIX_W-1:0] n_base,
  output logic [PIX_W-1:0] n_len,
  output logic             first_d,
  output logic             last_d,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  state_e state;
  layer_e lt;
  logic [CH_W-1:0] in_c_q, out_c_q, tile_d_q, tile_k_q, kb, kl, db, dl;
  logic [PIX_W-1:0] num_pix_q, tile_n_q, nb, nl;
  logic kw, nw, dw_wrap, fin, hs, clr, is_dw, cd, illegal;
  tile_desc_t desc, nd;
  assign hs = state == EMIT && desc_ready;
  assign clr = state == IDLE && start;
  assign is_dw = lt == DW;
  assign cd = is_dw || dw_wrap;
  assign illegal = tile_n_q == '0 || tile_d_q == '0 || tile_k_q == '0 || num_pix_q == '0 ||
                   out_c_q == '0 || (!is_dw && in_c_q == '0) || tile_k_q > out_c_q ||
                   (!is_dw && tile_d_q > in_c_q);
  // counters advance on the handshake so STEP already sees the next tile
  tile_axis_cnt #(.W(CH_W)) u_k (
    .clk(clk), .rst(rst), .clr(clr), .inc(hs && cd && nw), .total(out_c_q), .tile(tile_k_q),
    .base(kb), .len(kl), .wrap(kw)
  );
  tile_axis_cnt #(.W(PIX_W)) u_n (
    .clk(clk), .rst(rst), .clr(clr), .inc(hs && cd), .total(num_pix_q), .tile(tile_n_q),
    .base(nb), .len(nl), .wrap(nw)
  );
  tile_axis_cnt #(.W(CH_W)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .inc(hs), .total(in_c_q), .tile(tile_d_q),
    .base(db), .len(dl), .wrap(dw_wrap)
  );
  always_comb begin
    nd.k_base = kb;
    nd.k_len = kl;
    nd.n_base = nb;
    nd.n_len = nl;
    nd.d_base = is_dw ? kb : db;
    nd.d_len = is_dw ? kl : dl;
    nd.first_d = is_dw || db == '0;
    nd.last_d = is_dw || ({1'b0, db} + {1'b0, dl} == {1'b0, in_c_q});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lt <= PW;
      {in_c_q, out_c_q, tile_d_q, tile_k_q, num_pix_q, tile_n_q} <= '0;
      desc <= '0;
      {desc_valid, busy, done, cfg_err, fin} <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lt <= layer_e'(layer_type);
            {in_c_q, out_c_q, tile_d_q, tile_k_q} <= {in_C, out_C, tile_D, tile_K};
            {num_pix_q, tile_n_q} <= {num_pix, tile_n};
            cfg_err <= 1'b0;
            busy <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (illegal) begin
            cfg_err <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
            state <= FINISH;
          end else begin
            desc <= nd;
            desc_valid <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            fin <= cd && nw && kw;
            state <= STEP;
          end
        end
        STEP: begin
          if (fin) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= FINISH;
          end else begin
            desc <= nd;
            desc_valid <= 1'b1;
            state <= EMIT;
          end
        end
        FINISH: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign d_base = desc.d_base;
  assign d_len = desc.d_len;
  assign k_base = desc.k_base;
  assign k_len = desc.k_len;
  assign n_base = desc.n_base;
  assign n_len = desc.n_len;
  assign first_d = desc.first_d;
  assign last_d = desc.last_d;
endmodule

// File: tb/tb_tile_loop_ctrl.sv
// tb_tile_loop_ctrl: scoreboard bench for tile_loop_ctrl against a loop-nest model.
module tb_tile_loop_ctrl;
  logic clk = 0, rst = 1, start = 0, desc_ready = 0;
  logic [1:0] layer_type = 0;
  logic [6:0] in_C = 0, out_C = 0, tile_D = 0, tile_K = 0;
  logic [31:0] num_pix = 0, tile_n = 0;
  logic desc_valid, first_d, last_d, busy, done, cfg_err;
  logic [6:0] d_base, d_len, k_base, k_len;
  logic [31:0] n_base, n_len;
  tile_loop_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .layer_type(layer_type), .in_C(in_C), .out_C(out_C),
    .num_pix(num_pix), .tile_D(tile_D), .tile_K(tile_K), .tile_n(tile_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .d_base(d_base), .d_len(d_len),
    .k_base(k_base), .k_len(k_len), .n_base(n_base), .n_len(n_len), .first_d(first_d),
    .last_d(last_d), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  typedef logic [93:0] dv_t;
  dv_t exp_q[$];
  dv_t act, held;
  int total = 0, bad = 0, cyc = 0, n_hs = 0, last_hs = 0, stall_pct = 0;
  bit hold_lo = 0, stall_prev = 0, expect_done = 0;
  assign act = {d_base, d_len, k_base, k_len, n_base, n_len, first_d, last_d};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1 desc_ready = hold_lo ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
  end
  // monitor: pops the scoreboard on every handshake, checks hold stability and done
  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev && desc_valid) chk("stable", act, held);
      stall_prev = desc_valid && !desc_ready;
      held = act;
      if (desc_valid && desc_ready) begin
        n_hs++;
        last_hs = cyc;
        chk("desc_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("desc", act, exp_q.pop_front());
      end
      if (done) begin
        chk("done_expected", expect_done, 1);
        expect_done = 0;
      end
    end
  end
  task automatic model(input int t, ic, oc, np, td, tk, tn);
    exp_q.delete();
    for (int k = 0; k < oc; k += tk) begin
      int kl = (oc - k < tk) ? oc - k : tk;
      for (int n = 0; n < np; n += tn) begin
        int nl = (np - n < tn) ? np - n : tn;
        if (t == 1) exp_q.push_back({7'(k), 7'(kl), 7'(k), 7'(kl), 32'(n), 32'(nl), 1'b1, 1'b1});
        else for (int d = 0; d < ic; d += td) begin
          int dl = (ic - d < td) ? ic - d : td;
          exp_q.push_back({7'(d), 7'(dl), 7'(k), 7'(kl), 32'(n), 32'(nl), d == 0, d + dl == ic});
        end
      end
    end
  endtask
  task automatic kick(input int t, ic, oc, np, td, tk, tn, output int st);
    @(posedge clk);
    #1;
    layer_type = 2'(t); in_C = 7'(ic); out_C = 7'(oc); num_pix = 32'(np);
    tile_D = 7'(td); tile_K = 7'(tk); tile_n = 32'(tn); start = 1;
    st = cyc;
    @(posedge clk);
    #1 start = 0;
    layer_type = 2'($urandom); in_C = 7'($urandom); out_C = 7'($urandom);
    tile_D = 7'($urandom); tile_K = 7'($urandom); num_pix = $urandom; tile_n = $urandom;
  endtask
  task automatic run(input int t, ic, oc, np, td, tk, tn, pct, input bit err);
    int st, cnt;
    bit got;
    if (err) exp_q.delete(); else model(t, ic, oc, np, td, tk, tn);
    cnt = err ? 0 : ((oc + tk - 1) / tk) * ((np + tn - 1) / tn) * (t == 1 ? 1 : (ic + td - 1) / td);
    stall_pct = pct;
    n_hs = 0;
    expect_done = 1;
    kick(t, ic, oc, np, td, tk, tn, st);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    got = 0;
    for (int i = 0; i < 30000 && !got; i++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("cfg_err", cfg_err, err);
      chk("busy_at_done", busy, 0);
      chk("desc_count", n_hs, cnt);
      chk("queue_left", exp_q.size(), 0);
      chk("done_latency", cyc - (err ? st : last_hs), 2);
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask
  initial begin
    int st, ic, oc, np, td, tk, tn, t;
    bit got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", desc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_fields", act, 0);
    @(posedge clk);
    #1 rst = 0;
    run(0, 64, 32, 100, 32, 32, 48, 0, 0);
    run(1, 0, 10, 9, 3, 4, 9, 0, 0);
    run(2, 20, 13, 17, 6, 5, 7, 40, 0);
    run(3, 100, 50, 1, 30, 16, 1, 30, 0);
    run(0, 64, 32, 100, 32, 32, 0, 0, 1);
    chk("err_sticky", cfg_err, 1);
    run(0, 64, 32, 100, 32, 40, 48, 0, 1);
    run(2, 0, 8, 5, 4, 4, 5, 0, 1);
    run(0, 10, 8, 5, 12, 4, 5, 0, 1);
    run(0, 127, 127, 1, 127, 127, 1, 20, 0);
    for (int r = 0; r < 12; r++) begin
      t = $urandom_range(0, 3);
      oc = $urandom_range(1, 16); tk = $urandom_range((oc + 3) / 4, oc);
      ic = $urandom_range(1, 16); td = $urandom_range((ic + 3) / 4, ic);
      np = $urandom_range(1, 20); tn = $urandom_range((np + 3) / 4, np + 5);
      run(t, ic, oc, np, td, tk, tn, $urandom_range(0, 60), 0);
    end
    // reset while the third descriptor is stalled, then a clean rerun
    model(0, 64, 32, 100, 32, 32, 48);
    stall_pct = 0;
    n_hs = 0;
    expect_done = 0;
    kick(0, 64, 32, 100, 32, 32, 48, st);
    for (int i = 0; i < 50 && n_hs < 2; i++) @(negedge clk);
    hold_lo = 1;
    chk("reached_two", n_hs, 2);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = desc_valid;
    end
    chk("third_valid", got, 1);
    @(posedge clk);
    #1 rst = 1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", desc_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 0;
    hold_lo = 0;
    repeat (6) @(negedge clk);
    chk("no_done_after_rst", done, 0);
    run(0, 64, 32, 100, 32, 32, 48, 25, 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
